freq_meter_multi: RTL and testbench

Parametrised multi-channel frequency meter: the next generation of the single-channel gate-counter meter. Counts rising edges on CHANNELS asynchronous input signals over a programmable gate window of GATE_CYCLES cycles of one standard clock, then publishes all per-channel counts together with a one-cycle valid pulse. Supports continuous and single-shot measurement modes, and optional overflow saturation. Sits between raw signal inputs (pins, dividers) and display/readout logic.

---
 rtl/freq_meter_multi.sv | 151 +++++++++++++++
 tb/tb_freq_meter_multi.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter_multi.sv
// freq_meter_multi: multi-channel gate-window frequency meter.
// Each asynchronous input is synchronised and edge-detected. Rising edges are
// counted over a gate window of GATE_CYCLES standard-clock cycles. At the end
// of the window all channel counts are published together with a one-cycle
// meas_valid pulse. Supports continuous and single-shot measurement modes.
// Optional feature macro: FREQ_MEAS_OVF_SAT_EN. When it is defined, the edge
// counters saturate and the ovf flags are reported. When it is not defined,
// the counters wrap and ovf stays 0.

module freq_meter_multi #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 13,
    parameter int GATE_CYCLES = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      frequency_std_clk,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       sig_in,
    input  logic                      mode,
    input  logic                      start,
    output logic                      busy,
    output logic                      meas_valid,
    output logic [CHANNELS*CNT_W-1:0] freq_out,
    output logic [CHANNELS-1:0]       ovf
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    state_t                              state;
    logic [GATE_W-1:0]                   gate_cnt;
    logic                                warm_done;
    logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q;
    logic [CHANNELS-1:0]                 sync_out;
    logic [CHANNELS-1:0]                 prev_q;
    logic [CHANNELS-1:0]                 rise;
    logic [CHANNELS-1:0][CNT_W-1:0]      cnt_q;
    logic [CHANNELS-1:0][CNT_W-1:0]      cnt_next;
`ifdef FREQ_MEAS_OVF_SAT_EN
    logic [CHANNELS-1:0]                 sat_next;
`endif

    // Synchroniser chains and previous-value registers used for edge detection.
    always_ff @(posedge frequency_std_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], sig_in[ch]};
                prev_q[ch] <= sync_q[ch][SYNC_STAGES-1];
            end
        end
    end

    // A rising edge is a synchronised high whose value one cycle earlier was low.
    always_comb begin
        sync_out = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            sync_out[ch] = sync_q[ch][SYNC_STAGES-1];
        end
        rise = sync_out & ~prev_q;
    end

`ifdef FREQ_MEAS_OVF_SAT_EN
    // Next count per channel, held at all-ones once saturated. A channel is
    // flagged whenever it sits at the ceiling, because hitting the ceiling
    // exactly cannot be told apart from overrunning it.
    always_comb begin
        cnt_next = cnt_q;
        sat_next = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (cnt_q[ch] == CNT_MAX) begin
                cnt_next[ch] = CNT_MAX;
            end else begin
                cnt_next[ch] = cnt_q[ch] + CNT_W'(rise[ch]);
            end
            sat_next[ch] = (cnt_next[ch] == CNT_MAX);
        end
    end
`else
    // Next count per channel, wrapping modulo 2^CNT_W.
    always_comb begin
        cnt_next = cnt_q;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            cnt_next[ch] = cnt_q[ch] + CNT_W'(rise[ch]);
        end
    end
`endif

    // Gate FSM. It runs the window counter and the edge counters, and publishes
    // the results. The first window after reset is only a warm-up and is discarded.
    always_ff @(posedge frequency_std_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            cnt_q      <= '0;
            warm_done  <= 1'b0;
            busy       <= 1'b0;
            meas_valid <= 1'b0;
            freq_out   <= '0;
            ovf        <= '0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    cnt_q    <= '0;
                    if (!mode || start) begin
                        state <= GATE;
                        busy  <= 1'b1;
                    end
                end
                GATE: begin
                    if (gate_cnt == GATE_LAST) begin
                        gate_cnt  <= '0;
                        cnt_q     <= '0;
                        warm_done <= 1'b1;
                        if (warm_done) begin
                            meas_valid <= 1'b1;
                            freq_out   <= cnt_next;
`ifdef FREQ_MEAS_OVF_SAT_EN
                            ovf        <= sat_next;
`else
                            ovf        <= '0;
`endif
                        end
                        if (mode) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gate_cnt <= gate_cnt + GATE_W'(1);
                        cnt_q    <= cnt_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter_multi.sv
// tb_freq_meter_multi: directed bench for freq_meter_multi.
// The DUT is configured with two channels, 4-bit counters and a 100-cycle gate.

module tb_freq_meter_multi;

    localparam int CHANNELS = 2;
    localparam int CNT_W    = 4;
    localparam int GATE     = 100;
    // The first result after reset arrives after one IDLE cycle plus two windows.
    localparam int FIRST_LAT = 2 * GATE + 1;

`ifdef FREQ_MEAS_OVF_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                      frequency_std_clk = 1'b0;
    logic                      reset_n = 1'b1;
    logic [CHANNELS-1:0]       sig_in;
    logic                      mode = 1'b0;
    logic                      start = 1'b0;
    logic                      busy;
    logic                      meas_valid;
    logic [CHANNELS*CNT_W-1:0] freq_out;
    logic [CHANNELS-1:0]       ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Per-channel stimulus shape: period in clocks, or 0 for a constant level.
    int per [CHANNELS];
    bit lvl [CHANNELS];
    int ph  [CHANNELS];

    typedef struct {
        string      name;
        int         per0;
        bit         lvl0;
        int         per1;
        bit         lvl1;
        int         exp0;
        int         exp1;
        logic [1:0] exp_ovf;
    } vec_t;

    vec_t vecs [6];

    freq_meter_multi #(
        .CHANNELS   (CHANNELS),
        .CNT_W      (CNT_W),
        .GATE_CYCLES(GATE),
        .SYNC_STAGES(2)
    ) dut (
        .frequency_std_clk(frequency_std_clk),
        .reset_n          (reset_n),
        .sig_in           (sig_in),
        .mode             (mode),
        .start            (start),
        .busy             (busy),
        .meas_valid       (meas_valid),
        .freq_out         (freq_out),
        .ovf              (ovf)
    );

    // 100 MHz standard clock.
    initial forever #5 frequency_std_clk = ~frequency_std_clk;

    // Cycle counter used for latency and period measurements.
    always @(posedge frequency_std_clk) cyc <= cyc + 1;

    // Input waveform generator. It updates on the falling edge so that the
    // synchronisers always sample a settled level.
    initial begin
        for (int c = 0; c < CHANNELS; c++) begin
            per[c] = 0;
            lvl[c] = 1'b0;
            ph[c]  = 0;
        end
        sig_in = '0;
        forever begin
            @(negedge frequency_std_clk);
            for (int c = 0; c < CHANNELS; c++) begin
                if (per[c] == 0) begin
                    sig_in[c] = lvl[c];
                end else begin
                    ph[c] = (ph[c] + 1) % per[c];
                    sig_in[c] = (ph[c] < per[c] / 2);
                end
            end
        end
    end

    // Watchdog, in case a bounded wait is ever bypassed.
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge frequency_std_clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic wait_valid(input int budget, output int at_cyc);
        int n;
        at_cyc = -1;
        n = 0;
        while (at_cyc < 0 && n < budget) begin
            tick();
            n++;
            if (meas_valid === 1'b1) at_cyc = cyc;
        end
    endtask

    task automatic apply_stimulus(input int p0, input bit l0, input int p1, input bit l1,
                                  input bit m, output int rel_cyc);
        tick();
        reset_n = 1'b0;
        per[0] = p0;
        lvl[0] = l0;
        per[1] = p1;
        lvl[1] = l1;
        mode = m;
        start = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic check_result(input string tag, input int e0, input int e1, input logic [1:0] eo);
        check_output({tag, "_ch0"}, 32'(freq_out[CNT_W-1:0]), 32'(e0));
        check_output({tag, "_ch1"}, 32'(freq_out[2*CNT_W-1:CNT_W]), 32'(e1));
        check_output({tag, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    // One single-shot window, with an extra start pulse injected mid-window.
    task automatic run_single_shot(input bit expect_valid, input string tag);
        int busy_len;
        int valids;
        int idle_act;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_len = 0;
        valids = 0;
        while (busy === 1'b1 && busy_len < 300) begin
            if (meas_valid === 1'b1) valids++;
            busy_len++;
            if (busy_len == 50) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check_output({tag, "_busy_len"}, 32'(busy_len), 32'(GATE));
        check_output({tag, "_mid_valid"}, 32'(valids), 32'd0);
        check_output({tag, "_end_valid"}, 32'(meas_valid), 32'(expect_valid));
        check_result(tag, expect_valid ? 10 : 0, expect_valid ? 4 : 0, 2'b00);
        idle_act = 0;
        repeat (250) begin
            tick();
            if (busy !== 1'b0 || meas_valid !== 1'b0) idle_act++;
        end
        check_output({tag, "_idle_activity"}, 32'(idle_act), 32'd0);
    endtask

    initial begin
        int rel;
        int v1;
        int v2;
        int act;

        vecs[0] = '{"p10_p25", 10, 1'b0, 25, 1'b0, 10, 4, 2'b00};
        vecs[1] = '{"const0", 0, 1'b0, 0, 1'b0, 0, 0, 2'b00};
        vecs[2] = '{"const1", 0, 1'b1, 0, 1'b1, 0, 0, 2'b00};
        vecs[3] = '{"p2_p10", 2, 1'b0, 10, 1'b0, SAT ? 15 : 2, 10, SAT ? 2'b01 : 2'b00};
        vecs[4] = '{"p4_p20", 4, 1'b0, 20, 1'b0, SAT ? 15 : 9, 5, SAT ? 2'b01 : 2'b00};
        vecs[5] = '{"p50_p100", 50, 1'b0, 100, 1'b0, 2, 1, 2'b00};

        // Reset values.
        #2 reset_n = 1'b0;
        repeat (3) tick();
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_valid", 32'(meas_valid), 32'd0);
        check_output("rst_freq", 32'(freq_out), 32'd0);
        check_output("rst_ovf", 32'(ovf), 32'd0);

        // Continuous-mode vectors: first-result latency, values, pulse width, period.
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].per0, vecs[i].lvl0, vecs[i].per1, vecs[i].lvl1, 1'b0, rel);
            wait_valid(FIRST_LAT + 50, v1);
            check_output({vecs[i].name, "_first_lat"}, 32'(v1 - rel), 32'(FIRST_LAT));
            check_result({vecs[i].name, "_w1"}, vecs[i].exp0, vecs[i].exp1, vecs[i].exp_ovf);
            tick();
            check_output({vecs[i].name, "_pulse"}, 32'(meas_valid), 32'd0);
            wait_valid(GATE + 50, v2);
            check_output({vecs[i].name, "_period"}, 32'(v2 - v1), 32'(GATE));
            check_result({vecs[i].name, "_w2"}, vecs[i].exp0, vecs[i].exp1, vecs[i].exp_ovf);
        end

        // Single-shot mode: a warm-up window with no result, then a real one.
        apply_stimulus(10, 1'b0, 25, 1'b0, 1'b1, rel);
        act = 0;
        repeat (5) begin
            tick();
            if (busy !== 1'b0) act++;
        end
        check_output("ss_idle_wait", 32'(act), 32'd0);
        run_single_shot(1'b0, "ss_warm");
        run_single_shot(1'b1, "ss_meas");

        // Reset asserted mid-window clears outputs at once and restarts the warm-up.
        apply_stimulus(10, 1'b0, 25, 1'b0, 1'b0, rel);
        wait_valid(FIRST_LAT + 50, v1);
        repeat (50) tick();
        check_output("mid_rst_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_valid", 32'(meas_valid), 32'd0);
        check_output("mid_rst_freq", 32'(freq_out), 32'd0);
        check_output("mid_rst_ovf", 32'(ovf), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        rel = cyc;
        wait_valid(FIRST_LAT + 50, v1);
        check_output("mid_rst_first_lat", 32'(v1 - rel), 32'(FIRST_LAT));
        check_result("mid_rst_w", 10, 4, 2'b00);

        // Mode switched to single-shot mid-window: the window completes, then IDLE.
        apply_stimulus(10, 1'b0, 25, 1'b0, 1'b0, rel);
        wait_valid(FIRST_LAT + 50, v1);
        repeat (50) tick();
        mode = 1'b1;
        wait_valid(GATE + 50, v2);
        check_output("mode_sw_period", 32'(v2 - v1), 32'(GATE));
        check_output("mode_sw_busy", 32'(busy), 32'd0);
        check_result("mode_sw_w", 10, 4, 2'b00);
        act = 0;
        repeat (150) begin
            tick();
            if (busy !== 1'b0 || meas_valid !== 1'b0) act++;
        end
        check_output("mode_sw_idle_activity", 32'(act), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
